seq_detect_param: RTL

Parametrised Mealy serial pattern detector with a runtime-loadable pattern. Successor to the fixed 4-bit "1101" detector, adding:
- configurable pattern width;
- selectable overlapping or non-overlapping matching;
- an input qualifier;
- a registered match output and a saturating match counter.

It sits on a 1-bit serial data path and flags each completion of the programmed bit sequence.

---
 rtl/seq_detect_param.sv | 99 +++++++++
 1 files changed

// File: rtl/seq_detect_param.sv
// Parametrised Mealy serial pattern detector with a runtime-loadable pattern,
// selectable overlapping/non-overlapping matching and a saturating match counter.
module seq_detect_param #(
    parameter int               PAT_W     = 4,
    parameter logic [PAT_W-1:0] PAT_RESET = 4'b1101,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap,
    input  logic             din_valid,
    input  logic             din,
    output logic             match,
    output logic             match_q,
    output logic             armed,
    output logic [CNT_W-1:0] match_count
);

    localparam int               FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [PAT_W-1:0]  pat_reg,   pat_next;
    logic [PAT_W-2:0]  hist_reg,  hist_next;
    logic [FILL_W-1:0] fill_reg,  fill_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              match_q_reg;

    // The candidate window is the stored history with the current bit appended
    // as the newest (LSB) position; pat_reg[PAT_W-1] is the oldest bit in time.
    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] bit_eq;
    logic             beat;
    logic             flush;

    assign window = {hist_reg, din};

    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
            assign bit_eq[gi] = (window[gi] == pat_reg[gi]);
        end
    endgenerate

    assign armed = (fill_reg == FILL_MAX);
    assign beat  = din_valid & ~clear & ~load;
    // Gating by armed keeps the reset-time zeros in hist from ever matching.
    assign match = beat & armed & (&bit_eq);
    assign flush = match & ~overlap;

    always_comb begin
        pat_next   = pat_reg;
        hist_next  = hist_reg;
        fill_next  = fill_reg;
        count_next = count_reg;
        if (clear) begin
            hist_next  = '0;
            fill_next  = '0;
            count_next = '0;
        end else if (load) begin
            pat_next  = pat_in;
            hist_next = '0;
            fill_next = '0;
        end else if (din_valid) begin
            if (flush) begin
                hist_next = '0;
                fill_next = '0;
            end else begin
                hist_next = window[PAT_W-2:0];
                if (!armed)
                    fill_next = fill_reg + FILL_W'(1);
            end
            if (match && (count_reg != CNT_MAX))
                count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_reg     <= PAT_RESET;
            hist_reg    <= '0;
            fill_reg    <= '0;
            count_reg   <= '0;
            match_q_reg <= 1'b0;
        end else begin
            pat_reg     <= pat_next;
            hist_reg    <= hist_next;
            fill_reg    <= fill_next;
            count_reg   <= count_next;
            match_q_reg <= match;
        end
    end

    assign match_q     = match_q_reg;
    assign match_count = count_reg;

endmodule
